// File: rtl/jpeg_block_sequencer.sv
// Frame-level sequencer between zigzag/quantizer and run-length encoder:
// 8x8 block and MCU counting, component tagging, DC differencing, restart intervals.
module jpeg_block_sequencer #(
  parameter int SUBSAMPLE = 1,
  parameter int CW        = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   mcu_total,
  input  logic [15:0]   restart_interval,
  input  logic          ena_in,
  input  logic [CW-1:0] coef_in,
  output logic          rdy_out,
  output logic          ena_out,
  output logic [CW:0]   coef_out,
  input  logic          rdy_in,
  input  logic          enc_done,
  output logic [1:0]    comp_id,
  output logic          rst_req,
  input  logic          rst_ack,
  output logic [2:0]    rst_num,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [2:0] LAST_BLK = (SUBSAMPLE != 0) ? 3'd5 : 3'd2;

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, RESTART, FINISH} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mcu_tot_q, mcu_tot_d;
  logic [15:0]   rint_q, rint_d;
  logic [15:0]   mcu_cnt_q, mcu_cnt_d;
  logic [15:0]   rcnt_q, rcnt_d;
  logic [2:0]    blk_q, blk_d;
  logic [2:0]    rst_num_q, rst_num_d;
  logic [1:0]    comp_q, comp_d;
  logic [5:0]    idx_q, idx_d;
  logic [CW-1:0] pred_q [3];
  logic [CW-1:0] pred_d [3];
  logic          busy_q, fd_q, rreq_q;

  logic          beat;
  logic          mcu_done;
  logic [CW-1:0] pred_sel;

  function automatic logic [1:0] comp_of(input logic [2:0] blk);
    if (SUBSAMPLE != 0) begin
      if (blk < 3'd4)       comp_of = 2'd0;
      else if (blk == 3'd4) comp_of = 2'd1;
      else                  comp_of = 2'd2;
    end else begin
      comp_of = blk[1:0];
    end
  endfunction

  always_comb begin
    case (comp_q)
      2'd1:    pred_sel = pred_q[1];
      2'd2:    pred_sel = pred_q[2];
      default: pred_sel = pred_q[0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mcu_tot_d = mcu_tot_q;
    rint_d    = rint_q;
    mcu_cnt_d = mcu_cnt_q;
    rcnt_d    = rcnt_q;
    blk_d     = blk_q;
    rst_num_d = rst_num_q;
    comp_d    = comp_q;
    idx_d     = idx_q;
    for (int unsigned i = 0; i < 3; i++) pred_d[i] = pred_q[i];
    rdy_out   = 1'b0;
    ena_out   = 1'b0;
    coef_out  = '0;
    beat      = 1'b0;
    mcu_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          mcu_tot_d = (mcu_total == 16'd0) ? 16'd1 : mcu_total;
          rint_d    = restart_interval;
          mcu_cnt_d = '0;
          rcnt_d    = '0;
          blk_d     = '0;
          comp_d    = '0;
          idx_d     = '0;
          rst_num_d = '0;
          for (int unsigned i = 0; i < 3; i++) pred_d[i] = '0;
        end
      end
      STREAM: begin
        rdy_out = rdy_in;
        beat    = ena_in && rdy_in;
        ena_out = beat;
        if (idx_q == 6'd0)
          coef_out = {coef_in[CW-1], coef_in} - {pred_sel[CW-1], pred_sel};
        else
          coef_out = {coef_in[CW-1], coef_in};
        if (beat) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd0) begin
            for (int unsigned i = 0; i < 3; i++)
              if (comp_q == i[1:0]) pred_d[i] = coef_in;
          end
          if (idx_q == 6'd63) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (enc_done) begin
          if (blk_q == LAST_BLK) begin
            mcu_done  = 1'b1;
            blk_d     = '0;
            mcu_cnt_d = mcu_cnt_q + 16'd1;
            rcnt_d    = rcnt_q + 16'd1;
          end else begin
            blk_d = blk_q + 3'd1;
          end
          comp_d = comp_of(blk_d);
          // rcnt tracks MCUs since the last restart, avoiding a modulo on mcu_cnt
          if (mcu_done && mcu_cnt_d == mcu_tot_q) begin
            state_d = FINISH;
          end else if (mcu_done && rint_q != 16'd0 && rcnt_d == rint_q) begin
            state_d = RESTART;
            rcnt_d  = '0;
          end else begin
            state_d = STREAM;
          end
        end
      end
      RESTART: begin
        if (rst_ack) begin
          for (int unsigned i = 0; i < 3; i++) pred_d[i] = '0;
          rst_num_d = rst_num_q + 3'd1;
          state_d   = STREAM;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcu_tot_q <= '0;
      rint_q    <= '0;
      mcu_cnt_q <= '0;
      rcnt_q    <= '0;
      blk_q     <= '0;
      rst_num_q <= '0;
      comp_q    <= '0;
      idx_q     <= '0;
      for (int unsigned i = 0; i < 3; i++) pred_q[i] <= '0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      rreq_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcu_tot_q <= mcu_tot_d;
      rint_q    <= rint_d;
      mcu_cnt_q <= mcu_cnt_d;
      rcnt_q    <= rcnt_d;
      blk_q     <= blk_d;
      rst_num_q <= rst_num_d;
      comp_q    <= comp_d;
      idx_q     <= idx_d;
      for (int unsigned i = 0; i < 3; i++) pred_q[i] <= pred_d[i];
      busy_q    <= (state_d != IDLE);
      fd_q      <= (state_d == FINISH);
      rreq_q    <= (state_d == RESTART);
    end
  end

  assign comp_id    = comp_q;
  assign rst_num    = rst_num_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign rst_req    = rreq_q;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Bench for jpeg_block_sequencer: both MCU layouts, directed DC tables plus
// randomized frames checked against a frame-level block/predictor model.
module tb_jpeg_block_sequencer;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst, start, ena_in, rdy_in, enc_done, rst_ack;
  logic [15:0]   mcu_total, restart_interval;
  logic [CW-1:0] coef_in;
  int            sel;

  logic          rdy_o [2];
  logic          ena_o [2];
  logic          rreq_o[2];
  logic          busy_o[2];
  logic          fd_o  [2];
  logic [CW:0]   coef_o[2];
  logic [1:0]    comp_o[2];
  logic [2:0]    rnum_o[2];

  jpeg_block_sequencer #(.SUBSAMPLE(0), .CW(CW)) u_444 (
    .clk(clk), .rst(rst), .start(start && (sel == 0)), .mcu_total(mcu_total),
    .restart_interval(restart_interval), .ena_in(ena_in), .coef_in(coef_in),
    .rdy_out(rdy_o[0]), .ena_out(ena_o[0]), .coef_out(coef_o[0]), .rdy_in(rdy_in),
    .enc_done(enc_done), .comp_id(comp_o[0]), .rst_req(rreq_o[0]), .rst_ack(rst_ack),
    .rst_num(rnum_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0]));

  jpeg_block_sequencer #(.SUBSAMPLE(1), .CW(CW)) u_420 (
    .clk(clk), .rst(rst), .start(start && (sel == 1)), .mcu_total(mcu_total),
    .restart_interval(restart_interval), .ena_in(ena_in), .coef_in(coef_in),
    .rdy_out(rdy_o[1]), .ena_out(ena_o[1]), .coef_out(coef_o[1]), .rdy_in(rdy_in),
    .enc_done(enc_done), .comp_id(comp_o[1]), .rst_req(rreq_o[1]), .rst_ack(rst_ack),
    .rst_num(rnum_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1]));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {int sub; int mt; int ri; int gaps; int ack;} frame_t;
  typedef struct {int frame; int dc; int diff; int comp;} vec_t;

  frame_t fr[5];
  vec_t   vt[$];
  int     dcq[$];
  int     obs_diff[$];
  int     obs_comp[$];
  int     lay420[6] = '{0, 0, 0, 0, 1, 2};

  function automatic int sx(input logic [CW:0] v);
    return int'($signed(v));
  endfunction

  task automatic addv(input int f, input int dc, input int diff, input int comp);
    vec_t v;
    v.frame = f; v.dc = dc; v.diff = diff; v.comp = comp;
    vt.push_back(v);
  endtask

  // Drives one frame; the model derives each block's component from its MCU
  // position and tracks one DC predictor per component, zeroed at restarts.
  task automatic run_frame(input int sub, input int mt, input int ri, input bit gaps,
                           input int ack_delay, input int abort_blk);
    int nb, total, nblk, comp, exp_diff, rnum, k, budget, m;
    int pred[3];
    int ac[64];
    int dl[$];
    sel   = sub;
    nb    = sub ? 6 : 3;
    total = (mt == 0) ? 1 : mt;
    nblk  = nb * total;
    pred  = '{0, 0, 0};
    rnum  = 0;
    dl    = dcq;
    dcq.delete();
    obs_diff.delete();
    obs_comp.delete();
    while (dl.size() < nblk) dl.push_back(int'($urandom_range(0, 2047)) - 1024);
    mcu_total = 16'(mt); restart_interval = 16'(ri); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mcu_total = 16'($urandom); restart_interval = 16'($urandom);
    for (int b = 0; b < nblk; b++) begin
      comp     = sub ? lay420[b % nb] : b % nb;
      exp_diff = dl[b] - pred[comp];
      pred[comp] = dl[b];
      for (int j = 0; j < 64; j++) ac[j] = (j == 0) ? dl[b] : int'($urandom_range(0, 2047)) - 1024;
      k = 0; budget = 0;
      while (k < 64 && budget < 2000) begin
        ena_in  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        rdy_in  = gaps ? (budget % 2 == 1) : 1'b1;
        coef_in = ac[k][CW-1:0];
        if (gaps && $urandom_range(0, 15) == 0) start = 1'b1;
        if (gaps && $urandom_range(0, 15) == 0) rst_ack = 1'b1;
        if (b == abort_blk && k == 30) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0; ena_in = 1'b0; start = 1'b0; rst_ack = 1'b0;
          return;
        end
        @(negedge clk);
        chk("stream_rdy_out", rdy_o[sel], rdy_in);
        chk("stream_ena_out", ena_o[sel], ena_in && rdy_in);
        chk("stream_comp_id", comp_o[sel], comp);
        chk("stream_rst_req", rreq_o[sel], 0);
        chk("stream_rst_num", rnum_o[sel], rnum);
        chk("stream_busy", busy_o[sel], 1);
        chk("stream_frame_done", fd_o[sel], 0);
        if (ena_in && rdy_in) begin
          chk(k == 0 ? "dc_diff" : "ac_coef", sx(coef_o[sel]), k == 0 ? exp_diff : ac[k]);
          if (k == 0) begin
            obs_diff.push_back(sx(coef_o[sel]));
            obs_comp.push_back(int'(comp_o[sel]));
          end
          k++;
        end
        @(posedge clk); #1;
        start = 1'b0; rst_ack = 1'b0; budget++;
      end
      if (k < 64) chk("beat_budget", k, 64);
      ena_in = 1'b0;
      repeat (gaps ? $urandom_range(0, 2) : 0) begin
        rdy_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("drain_rdy_out", rdy_o[sel], 0);
        chk("drain_comp_id", comp_o[sel], comp);
        @(posedge clk); #1;
      end
      enc_done = 1'b1; rdy_in = 1'b1;
      @(negedge clk);
      chk("drain_rdy_out", rdy_o[sel], 0);
      chk("drain_ena_out", ena_o[sel], 0);
      chk("drain_comp_id", comp_o[sel], comp);
      @(posedge clk); #1;
      enc_done = 1'b0;
      m = b / nb + 1;
      if (b == nblk - 1) begin
        @(negedge clk);
        chk("frame_done_pulse", fd_o[sel], 1);
        chk("finish_busy", busy_o[sel], 1);
        chk("finish_rst_req", rreq_o[sel], 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("frame_done_single", fd_o[sel], 0);
        chk("idle_busy", busy_o[sel], 0);
        @(posedge clk); #1;
      end else if (b % nb == nb - 1 && ri != 0 && m % ri == 0) begin
        pred = '{0, 0, 0};
        @(negedge clk);
        chk("restart_req", rreq_o[sel], 1);
        chk("restart_num", rnum_o[sel], rnum);
        chk("restart_rdy_out", rdy_o[sel], 0);
        repeat (ack_delay) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("restart_hold_req", rreq_o[sel], 1);
          chk("restart_hold_rdy", rdy_o[sel], 0);
        end
        @(posedge clk); #1;
        rst_ack = 1'b1;
        @(posedge clk); #1;
        rst_ack = 1'b0;
        rnum = (rnum + 1) % 8;
      end
    end
  endtask

  task automatic run_directed(input int f);
    int n;
    n = 0;
    foreach (vt[i]) if (vt[i].frame == f) dcq.push_back(vt[i].dc);
    run_frame(fr[f].sub, fr[f].mt, fr[f].ri, 1'(fr[f].gaps), fr[f].ack, -1);
    foreach (vt[i]) begin
      if (vt[i].frame == f) begin
        if (n < obs_diff.size()) begin
          chk($sformatf("table_f%0d_b%0d_diff", f, n), obs_diff[n], vt[i].diff);
          chk($sformatf("table_f%0d_b%0d_comp", f, n), obs_comp[n], vt[i].comp);
        end
        n++;
      end
    end
    chk($sformatf("table_f%0d_blocks", f), obs_diff.size(), n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; ena_in = 1'b0; rdy_in = 1'b1; enc_done = 1'b0;
    rst_ack = 1'b0; coef_in = '0; mcu_total = '0; restart_interval = '0; sel = 0;

    fr[0] = '{0, 1, 0, 0, 0};
    fr[1] = '{1, 2, 0, 1, 0};
    fr[2] = '{0, 3, 1, 0, 5};
    fr[3] = '{0, 2, 0, 1, 0};
    fr[4] = '{0, 1, 0, 0, 0};
    addv(0, 50, 50, 0); addv(0, -3, -3, 1); addv(0, 7, 7, 2);
    addv(1, 10, 10, 0); addv(1, 12, 2, 0); addv(1, 9, -3, 0); addv(1, 9, 0, 0);
    addv(1, 5, 5, 1);   addv(1, -6, -6, 2);
    addv(1, 20, 11, 0); addv(1, 20, 0, 0); addv(1, 20, 0, 0); addv(1, 20, 0, 0);
    addv(1, 8, 3, 1);   addv(1, -6, 0, 2);
    for (int i = 0; i < 9; i++) addv(2, 100, 100, i % 3);
    addv(3, 1023, 1023, 0); addv(3, 0, 0, 1); addv(3, 0, 0, 2);
    addv(3, -1024, -2047, 0); addv(3, 0, 0, 1); addv(3, 0, 0, 2);
    addv(4, 40, 40, 0); addv(4, -5, -5, 1); addv(4, 6, 6, 2);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_busy", busy_o[s], 0);
      chk("reset_rdy_out", rdy_o[s], 0);
      chk("reset_ena_out", ena_o[s], 0);
      chk("reset_rst_req", rreq_o[s], 0);
      chk("reset_frame_done", fd_o[s], 0);
      chk("reset_comp_id", comp_o[s], 0);
      chk("reset_rst_num", rnum_o[s], 0);
      chk("reset_coef_out", sx(coef_o[s]), 0);
    end
    @(posedge clk); #1;

    for (int f = 0; f < 4; f++) run_directed(f);

    run_frame(0, 3, 1, 1'b1, 1, 4);
    @(negedge clk);
    chk("abort_busy", busy_o[0], 0);
    chk("abort_comp_id", comp_o[0], 0);
    chk("abort_rst_num", rnum_o[0], 0);
    chk("abort_rst_req", rreq_o[0], 0);
    chk("abort_rdy_out", rdy_o[0], 0);
    @(posedge clk); #1;
    run_directed(4);

    for (int r = 0; r < 5; r++)
      run_frame(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 1'b1, int'($urandom_range(0, 3)), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jpeg_block_sequencer.md
Name: jpeg_block_sequencer

Overview:
- Frame-level controller sitting between the quantizer/zigzag stage and the run-length encoder.
- Counts coefficients into 8x8 blocks and blocks into MCUs, and tags each block with its component (Y/Cb/Cr) so downstream Huffman tables can be selected.
- Replaces each block's DC coefficient with the DC difference against a per-component predictor.
- Inserts restart-interval boundaries (marker request plus predictor reset) and reports frame completion.

Parameters:
- SUBSAMPLE, 1, MCU layout: 0 = 4:4:4 (Y,Cb,Cr = 3 blocks per MCU); 1 = 4:2:0 (Y,Y,Y,Y,Cb,Cr = 6 blocks per MCU).
- CW, 11, signed coefficient width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches config and begins a frame (ignored unless IDLE)
- mcu_total  in  16  MCUs in frame (0 treated as 1)
- restart_interval  in  16  MCUs per restart interval; 0 = disabled
- ena_in  in  1  upstream coefficient valid
- coef_in  in  CW  quantized coefficient, zigzag order
- rdy_out  out  1  sequencer can accept a coefficient
- ena_out  out  1  coefficient valid to run encoder
- coef_out  out  CW+1  coefficient, or DC difference on index 0
- rdy_in  in  1  run encoder ready
- enc_done  in  1  run encoder end-of-block pulse
- comp_id  out  2  0 = Y, 1 = Cb, 2 = Cr for current block
- rst_req  out  1  request RSTn marker emission
- rst_ack  in  1  marker written
- rst_num  out  3  RSTn index, wraps 7 -> 0
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last block drains

Behaviour:
- Reset values: state IDLE; rdy_out, ena_out, rst_req, busy, frame_done = 0; coef_out = 0; comp_id = 0; rst_num = 0; all DC predictors = 0; all counters = 0. Reset mid-frame aborts immediately; partial blocks are discarded.
- States: IDLE, STREAM, DRAIN, RESTART, FINISH.
- IDLE:
  - start -> STREAM.
  - Latch mcu_total and restart_interval; clear predictors, block, MCU and coefficient counters, and rst_num.
- STREAM:
  - Output drive is purely combinational from inputs and state: rdy_out = rdy_in; ena_out = ena_in && rdy_in.
  - Beat = ena_in && rdy_in.
  - coef_idx (6 bit) increments per beat.
  - At coef_idx = 0: coef_out = coef_in - pred[comp_id], computed at CW+1 width with sign extension, no saturation; pred[comp_id] <= coef_in on that beat.
  - Otherwise coef_out = coef_in sign-extended.
  - Beat with coef_idx = 63 -> DRAIN; rdy_out drops the following cycle.
- DRAIN:
  - rdy_out = 0, ena_out = 0. Wait for enc_done; enc_done arriving in the same cycle as entry is honoured.
  - On enc_done, advance the block counter within the MCU (wraps at 3 or 6, which also increments mcu_cnt) and update comp_id per the SUBSAMPLE order.
  - Then:
    - If the completed MCU makes mcu_cnt = mcu_total -> FINISH.
    - Else if restart_interval != 0 and mcu_cnt mod restart_interval == 0 on MCU completion -> RESTART.
    - Else -> STREAM.
- RESTART:
  - rst_req = 1 and held until rst_ack.
  - On rst_ack: all predictors = 0, rst_num += 1 (mod 8), -> STREAM.
  - rst_ack asserted while rst_req = 0 is ignored.
  - No restart is issued after the final MCU.
- FINISH: frame_done = 1 for one cycle, then -> IDLE.
- busy = 1 in every state except IDLE.
- start while busy is ignored.
- comp_id is stable for the entire block, including DRAIN, and changes only on the enc_done transition.
- Latency: zero-cycle combinational pass-through of coefficients; block-to-block turnaround of 1 cycle after enc_done.

Test Plan:
- SUBSAMPLE = 0, mcu_total = 1, DC values Y = 50, Cb = -3, Cr = 7, all AC zero -> coef_out DC = 50, -3, 7; comp_id sequence 0, 1, 2; frame_done exactly once, 1 cycle after third enc_done.
- SUBSAMPLE = 1, mcu_total = 2, Y DCs 10, 12, 9, 9 then 4 more Y at 20 -> Y diffs 10, 2, -3, 0, 11, 0, 0, 0; Cb/Cr predictors independent of Y.
- restart_interval = 1, mcu_total = 3, SUBSAMPLE = 0, every DC = 100 -> rst_req after MCUs 1 and 2 only, rst_num 0 then 1 on successive requests; every DC diff = 100; holding rst_ack low 5 cycles stalls rdy_out low.
- Extreme diff: Y DC = 1023 then -1024 -> coef_out = -2047 on 12 bits, no wrap.
- rdy_in toggled every other cycle and ena_in gapped -> exactly 64 ena_out beats per block, no beat duplicated or lost; rdy_out = 0 throughout DRAIN.
- rst asserted at coefficient 30 of block 2, then start -> predictors zero, comp_id = 0, first DC diff equals raw DC.
